// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: measures incoming VGA sync timing, locks on a stable line period and regenerates active-video x/y.
module vga_sync_decoder #(
    parameter int H_START    = 144,
    parameter int H_ACTIVE   = 640,
    parameter int V_START    = 35,
    parameter int V_ACTIVE   = 480,
    parameter int LOCK_LINES = 4,
    parameter int TOL        = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_active,
    output logic        o_locked,
    output logic [11:0] o_line_len,
    output logic [10:0] o_frame_lines,
    output logic        o_new_frame,
    output logic        o_err
);
    localparam int MW = $clog2(LOCK_LINES + 1);
    localparam logic [11:0] TOL_W = 12'(TOL);
    localparam logic [11:0] HS = 12'(H_START);
    localparam logic [11:0] HE = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] VS = 11'(V_START);
    localparam logic [10:0] VE = 11'(V_START + V_ACTIVE);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_nx;
    logic hs_q, vs_q, vs_pend, frame_seen, frame_seen_nx, err_nx;
    logic hs_fall, vs_fall, frame_start, h_sat, match, hact, vact;
    logic [11:0] h_cnt, prev_len, len, diff;
    logic [10:0] v_cnt;
    logic [MW-1:0] match_cnt, match_cnt_nx;
    always_comb begin
        hs_fall = hs_q & ~i_hsync;
        vs_fall = vs_q & ~i_vsync;
        frame_start = hs_fall & (vs_pend | vs_fall);
        h_sat = (h_cnt == 12'hfff) & ~hs_fall;
        len = h_cnt + 12'd1;
        diff = (len > prev_len) ? len - prev_len : prev_len - len;
        match = diff <= TOL_W;
        hact = (h_cnt >= HS) && (h_cnt < HE);
        vact = (v_cnt >= VS) && (v_cnt < VE);
        o_active = hact & vact & o_locked & frame_seen;
        o_x = o_active ? 10'(h_cnt - HS) : 10'd0;
        o_y = o_active ? 10'(v_cnt - VS) : 10'd0;
    end
    always_comb begin
        state_nx = state;
        match_cnt_nx = match_cnt;
        frame_seen_nx = frame_seen;
        err_nx = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_fall) begin
                    state_nx = MEASURE;
                    match_cnt_nx = '0;
                end
            end
            MEASURE: begin
                if (h_sat) begin
                    state_nx = SEARCH;
                end else if (hs_fall) begin
                    if (!match) begin
                        match_cnt_nx = '0;
                    end else if (match_cnt == MW'(LOCK_LINES - 1)) begin
                        state_nx = LOCKED;
                        frame_seen_nx = 1'b0;
                    end else begin
                        match_cnt_nx = match_cnt + MW'(1);
                    end
                end
            end
            LOCKED: begin
                if (h_sat) begin
                    state_nx = SEARCH;
                    frame_seen_nx = 1'b0;
                end else if (hs_fall && !match) begin
                    state_nx = MEASURE;
                    match_cnt_nx = '0;
                    frame_seen_nx = 1'b0;
                    err_nx = 1'b1;
                end else if (frame_start) begin
                    frame_seen_nx = 1'b1;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= SEARCH;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            vs_pend <= 1'b0;
            frame_seen <= 1'b0;
            match_cnt <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
            prev_len <= '0;
            o_locked <= 1'b0;
            o_line_len <= '0;
            o_frame_lines <= '0;
            o_new_frame <= 1'b0;
            o_err <= 1'b0;
        end else begin
            state <= state_nx;
            hs_q <= i_hsync;
            vs_q <= i_vsync;
            frame_seen <= frame_seen_nx;
            match_cnt <= match_cnt_nx;
            o_locked <= (state_nx == LOCKED);
            o_new_frame <= frame_start;
            o_err <= err_nx;
            h_cnt <= hs_fall ? 12'd0 : (h_cnt == 12'hfff ? h_cnt : h_cnt + 12'd1);
            vs_pend <= frame_start ? 1'b0 : (vs_pend | vs_fall);
            if (hs_fall) begin
                o_line_len <= len;
                prev_len <= len;
            end
            // a vsync seen anywhere in the line restarts the frame at the next line boundary
            if (frame_start) begin
                o_frame_lines <= v_cnt + 11'd1;
                v_cnt <= '0;
            end else if (hs_fall && v_cnt != 11'h7ff) begin
                v_cnt <= v_cnt + 11'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of lock, coordinates, glitch, sync loss and reset on a scaled-down video timing.
module tb_vga_sync_decoder;
    localparam int L = 100;
    localparam int HSW = 12;
    localparam int H_S = 18;
    localparam int H_A = 64;
    localparam int V_S = 5;
    localparam int V_A = 20;
    localparam int FL = 30;
    logic clk = 1'b0, rst_n = 1'b1, hsync = 1'b1, vsync = 1'b1;
    logic [9:0] x0, y0, x1, y1;
    logic act0, act1, lk0, lk1, nf0, nf1, er0, er1;
    logic [11:0] len0, len1;
    logic [10:0] fl0, fl1;
    int n_cmp = 0, n_bad = 0, err0 = 0, err1 = 0, nfc = 0;
    int cl [7] = '{V_S, V_S, V_S - 1, V_S + V_A - 1, V_S + V_A - 1, V_S + V_A, 12};
    int ci [7] = '{H_S + 1, H_S, H_S + 1, H_S + H_A, H_S + H_A + 1, H_S + 1, 50};
    logic [20:0] ce [7] = '{{1'b1, 10'd0, 10'd0}, 21'd0, 21'd0, {1'b1, 10'd63, 10'd19}, 21'd0, 21'd0, {1'b1, 10'd31, 10'd7}};
    vga_sync_decoder #(.H_START(H_S), .H_ACTIVE(H_A), .V_START(V_S), .V_ACTIVE(V_A), .LOCK_LINES(4), .TOL(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
        .o_x(x0), .o_y(y0), .o_active(act0), .o_locked(lk0), .o_line_len(len0),
        .o_frame_lines(fl0), .o_new_frame(nf0), .o_err(er0));
    vga_sync_decoder #(.H_START(H_S), .H_ACTIVE(H_A), .V_START(V_S), .V_ACTIVE(V_A), .LOCK_LINES(4), .TOL(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
        .o_x(x1), .o_y(y1), .o_active(act1), .o_locked(lk1), .o_line_len(len1),
        .o_frame_lines(fl1), .o_new_frame(nf1), .o_err(er1));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        err0 <= err0 + int'(er0);
        err1 <= err1 + int'(er1);
        nfc <= nfc + int'(nf0);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            hsync = 1'b1;
            vsync = 1'b1;
        end
    endtask
    task automatic line(input int len, input bit vlow, input int n);
        for (int i = 0; i < n && i < len; i++) begin
            @(negedge clk);
            hsync = (i >= HSW);
            vsync = ~vlow;
        end
    endtask
    // outputs sampled at iteration i reflect h_cnt = i-1 and v_cnt = l
    task automatic frame(input bit chk);
        for (int l = 0; l < FL; l++) begin
            for (int i = 0; i < L; i++) begin
                @(negedge clk);
                if (chk) begin
                    for (int k = 0; k < 7; k++) begin
                        if (l == cl[k] && i == ci[k]) begin
                            check($sformatf("pix0_%0d", k), {act0, x0, y0}, ce[k]);
                            check($sformatf("pix1_%0d", k), {act1, x1, y1}, ce[k]);
                        end
                    end
                end
                hsync = (i >= HSW);
                vsync = (l >= 2);
            end
        end
    endtask
    // first fall lands when h_cnt has counted a full line since release, so the 5th fall locks
    task automatic start_lock;
        @(negedge clk);
        rst_n = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        idle(L - 2);
        repeat (4) line(L, 1'b0, L);
        check("lock_early0", lk0, 0);
        check("lock_early1", lk1, 0);
        line(L, 1'b0, L);
        check("lock0", lk0, 1);
        check("lock1", lk1, 1);
        check("line_len", len0, L);
    endtask
    initial begin
        #3 rst_n = 1'b0;
        #2;
        check("rst0", {x0, y0, act0, lk0, len0, fl0, nf0, er0}, 0);
        check("rst1", {x1, y1, act1, lk1, len1, fl1, nf1, er1}, 0);
        start_lock();
        check("act_prelock", act0, 0);
        frame(1'b1);
        check("frame_lines_first", fl0, 6);
        check("nf_count1", nfc, 1);
        frame(1'b0);
        check("frame_lines", fl0, FL);
        check("nf_count2", nfc, 2);
        line(L, 1'b0, L);
        line(L - 1, 1'b0, L - 1);
        line(L, 1'b0, L);
        check("glitch_len", len0, L - 1);
        check("glitch_err0", err0, 1);
        check("glitch_lock0", lk0, 0);
        check("glitch_err1", err1, 0);
        check("glitch_lock1", lk1, 1);
        repeat (4) line(L, 1'b0, L);
        check("relock_early", lk0, 0);
        line(L, 1'b0, L);
        check("relock", lk0, 1);
        idle(4096 - L + 1);
        check("sat_hold0", lk0, 1);
        check("sat_hold1", lk1, 1);
        idle(1);
        check("sat_drop0", lk0, 0);
        check("sat_drop1", lk1, 0);
        idle(5000 - (4096 - L + 2));
        check("sat_err0", err0, 1);
        check("sat_err1", err1, 0);
        repeat (5) line(L, 1'b0, L);
        check("resume_early0", lk0, 0);
        check("resume_early1", lk1, 0);
        line(L, 1'b0, L);
        check("resume0", lk0, 1);
        check("resume1", lk1, 1);
        line(L, 1'b0, 61);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst0", {x0, y0, act0, lk0, len0, fl0, nf0, er0}, 0);
        check("mid_rst1", {x1, y1, act1, lk1, len1, fl1, nf1, er1}, 0);
        start_lock();
        check("post_rst_err0", err0, 1);
        check("post_rst_err1", err1, 0);
        check("post_rst_nf", nfc, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator.
- Samples incoming active-low hsync/vsync, measures line length and frame height, and locks once line period is stable.
- Regenerates pixel x/y coordinates plus an active-video flag for downstream capture logic and for self-checking of the display path.
- Single clock domain: sync inputs are produced on, or already synchronised to, i_clk.

Parameters:
H_START, 144, pixel-clock count from hsync falling edge to first active pixel (sync + back porch)
H_ACTIVE, 640, active pixels per line
V_START, 35, line count from vsync assertion to first active line
V_ACTIVE, 480, active lines per frame
LOCK_LINES, 4, consecutive matching line lengths required to lock
TOL, 0, allowed absolute difference (clocks) between consecutive line lengths

Ports:
i_clk  in  1  pixel clock, all state on rising edge
i_reset_n  in  1  reset, asynchronous, active-low
i_hsync  in  1  horizontal sync, active-low
i_vsync  in  1  vertical sync, active-low
o_x  out  10  active-region pixel column, 0 outside active region
o_y  out  10  active-region line, 0 outside active region
o_active  out  1  high while (h,v) lies in active window and block is locked with a frame seen
o_locked  out  1  line timing locked
o_line_len  out  12  last measured line length in clocks
o_frame_lines  out  11  last measured frame height in lines
o_new_frame  out  1  one-cycle pulse when a new frame starts
o_err  out  1  one-cycle pulse when lock is lost

Behaviour:
- Reset (async): all registers 0, FSM = SEARCH. Outputs o_x=0, o_y=0, o_active=0, o_locked=0, o_line_len=0, o_frame_lines=0, o_new_frame=0, o_err=0. hs_q/vs_q reset to 1 (idle).
- Edge detect: hs_fall = hs_q & ~i_hsync; vs_fall = vs_q & ~i_vsync. hs_q/vs_q register the inputs every cycle.
- h_cnt (12b):
  - 0 on hs_fall, else h_cnt+1.
  - Saturates at 4095; saturation forces FSM to SEARCH (no sync timeout), o_locked=0, no o_err.
- Line measure: on hs_fall, len = h_cnt+1. o_line_len <= len. prev_len <= len.
- vsync handling:
  - vs_fall sets vs_pend.
  - On hs_fall with vs_pend, or with vs_fall in the same cycle: o_frame_lines <= v_cnt+1, v_cnt <= 0, vs_pend <= 0, o_new_frame pulses the following cycle.
  - On any other hs_fall, v_cnt <= v_cnt+1, saturating at 2047.
- FSM:
  - SEARCH: on first hs_fall -> MEASURE, match_cnt=0.
  - MEASURE, on each hs_fall:
    - Match (|len-prev_len| <= TOL): match_cnt++. When match_cnt reaches LOCK_LINES-1 before the increment -> LOCKED, frame_seen=0.
    - Mismatch: match_cnt=0, stay in MEASURE.
  - LOCKED, on hs_fall:
    - Mismatch: o_err pulses 1 cycle, -> MEASURE, match_cnt=0, frame_seen=0.
    - Match: stay in LOCKED.
  - LOCKED: the first frame start after lock sets frame_seen=1.
  - o_locked = (state==LOCKED), registered, asserted the cycle after the transition.
  - The first hs_fall after SEARCH has no valid prev_len and is never compared.
- Coordinates (combinational from registered counters, 0 latency relative to h_cnt/v_cnt):
  - hact = H_START <= h_cnt < H_START+H_ACTIVE.
  - vact = V_START <= v_cnt < V_START+V_ACTIVE.
  - o_active = hact & vact & o_locked & frame_seen.
  - When o_active: o_x = h_cnt-H_START and o_y = v_cnt-V_START, truncated to 10 bits. Otherwise both are 0.
- Simultaneous events:
  - hs_fall with vs_fall: frame restart wins, v_cnt=0 that cycle.
  - hs_fall on the same cycle as h_cnt saturation: hs_fall wins, counter clears, no SEARCH transition.
- Reset mid-frame: everything returns to reset values immediately. Relock needs a fresh first hs_fall plus LOCK_LINES matching lines.

Test Plan:
- 640x480@60 stimulus (800-clock line, 96-clock hsync, 525 lines, 2-line vsync) -> o_line_len=800; o_locked rises after the 5th hs_fall; o_frame_lines=525 after the second vsync.
- Locked, after first frame -> o_active first high at h_cnt=144, v_cnt=35 with o_x=0, o_y=0; last active pixel o_x=639, o_y=479; o_active=0 at h_cnt=784.
- One line shortened to 799 while locked, TOL=0 -> o_err one-cycle pulse, o_locked=0; relocks after 4 further matching 800 lines.
- Same 799 glitch with TOL=1 -> no o_err, o_locked stays 1.
- hsync held high for 5000 clocks -> at h_cnt=4095 o_locked drops, no o_err. Resuming sync relocks after the first hs_fall plus 4 matching lines.
- i_reset_n pulsed low mid-line at h_cnt=300 -> all outputs 0 asynchronously; o_new_frame/o_err do not pulse; normal lock sequence follows.
